// File: rtl/ofmap_bit_packer.sv
// Packs 1-bit activations into DATA_WIDTH-bit BRAM words with a per-bit write mask.
// Optional OFMAP_POPCOUNT_EN adds o_ones_count, which counts the accepted ones.
module ofmap_bit_packer #(
   parameter int DATA_WIDTH      = 32,
   parameter int BIT_ADDR_WIDTH  = 12,
   parameter int WORD_ADDR_WIDTH = BIT_ADDR_WIDTH - $clog2(DATA_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_data,
   input  logic [BIT_ADDR_WIDTH-1:0]  i_addr,
   input  logic                       i_valid,
   input  logic                       i_last,
   output logic                       bram_we,
   output logic [WORD_ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0]      bram_wdata,
   output logic [DATA_WIDTH-1:0]      bram_wmask,
   output logic                       o_done,
`ifdef OFMAP_POPCOUNT_EN
   output logic [BIT_ADDR_WIDTH:0]    o_ones_count,
`endif
   output logic [WORD_ADDR_WIDTH:0]   o_word_count
);

   localparam int BP_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                     state;
   logic                       hv;
   logic                       clr_pend;
   logic [WORD_ADDR_WIDTH-1:0] held_addr;
   logic [DATA_WIDTH-1:0]      held_data;
   logic [DATA_WIDTH-1:0]      held_mask;

   logic [WORD_ADDR_WIDTH-1:0] wa;
   logic [BP_W-1:0]            bp;
   logic [DATA_WIDTH-1:0]      bit_oh;
   logic [DATA_WIDTH-1:0]      load_data;
   logic [DATA_WIDTH-1:0]      merge_data;
   logic [DATA_WIDTH-1:0]      merge_mask;
   logic                       accept;
   logic                       miss;
   logic                       top_bit;
   logic                       emit;
   logic [WORD_ADDR_WIDTH-1:0] emit_addr;
   logic [DATA_WIDTH-1:0]      emit_data;
   logic [DATA_WIDTH-1:0]      emit_mask;
   logic [WORD_ADDR_WIDTH:0]   wc_base;
   logic [WORD_ADDR_WIDTH:0]   wc_next;

   always_comb begin
      wa         = i_addr[BIT_ADDR_WIDTH-1:BP_W];
      bp         = i_addr[BP_W-1:0];
      bit_oh     = DATA_WIDTH'(1) << bp;
      load_data  = i_data ? bit_oh : '0;
      accept     = i_valid && (state == S_RUN);
      miss       = hv && (wa != held_addr);
      top_bit    = &bp;
      merge_data = ((hv ? held_data : '0) & ~bit_oh) | load_data;
      merge_mask = (hv ? held_mask : '0) | bit_oh;

      // A new word address flushes the old word first; the new top bit then only reloads.
      emit      = 1'b0;
      emit_addr = held_addr;
      emit_data = held_data;
      emit_mask = held_mask;
      if (accept) begin
         if (miss) begin
            emit = 1'b1;
         end else if (top_bit) begin
            emit      = 1'b1;
            emit_addr = wa;
            emit_data = merge_data;
            emit_mask = merge_mask;
         end
      end else if (state == S_FLUSH) begin
         emit = hv;
      end

      wc_base = (accept && clr_pend) ? '0 : o_word_count;
      wc_next = (emit && (wc_base != '1)) ? wc_base + (WORD_ADDR_WIDTH+1)'(1) : wc_base;
   end

`ifdef OFMAP_POPCOUNT_EN
   logic [BIT_ADDR_WIDTH:0] ones_base;
   always_comb begin
      ones_base = (accept && clr_pend) ? '0 : o_ones_count;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ones_count <= '0;
      end else if (accept) begin
         o_ones_count <= (i_data && (ones_base != '1)) ?
                         ones_base + (BIT_ADDR_WIDTH+1)'(1) : ones_base;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_RUN;
         hv           <= 1'b0;
         clr_pend     <= 1'b0;
         held_addr    <= '0;
         held_data    <= '0;
         held_mask    <= '0;
         bram_we      <= 1'b0;
         bram_addr    <= '0;
         bram_wdata   <= '0;
         bram_wmask   <= '0;
         o_done       <= 1'b0;
         o_word_count <= '0;
      end else begin
         bram_we      <= emit;
         o_done       <= 1'b0;
         o_word_count <= wc_next;
         if (emit) begin
            bram_addr  <= emit_addr;
            bram_wdata <= emit_data;
            bram_wmask <= emit_mask;
         end
         case (state)
            S_RUN: begin
               if (accept) begin
                  clr_pend <= 1'b0;
                  if (miss) begin
                     held_addr <= wa;
                     held_data <= load_data;
                     held_mask <= bit_oh;
                  end else if (top_bit) begin
                     hv <= 1'b0;
                  end else begin
                     hv        <= 1'b1;
                     held_addr <= wa;
                     held_data <= merge_data;
                     held_mask <= merge_mask;
                  end
               end
               if (i_last) state <= S_FLUSH;
            end
            S_FLUSH: begin
               hv    <= 1'b0;
               state <= S_DONE;
            end
            S_DONE: begin
               o_done   <= 1'b1;
               clr_pend <= 1'b1;
               state    <= S_RUN;
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Self-checking bench for ofmap_bit_packer: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the packing rules.
module tb_ofmap_bit_packer;

   localparam int W   = 32;
   localparam int BAW = 12;
   localparam int WAW = 7;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           i_data = 1'b0;
   logic [BAW-1:0] i_addr = '0;
   logic           i_valid = 1'b0;
   logic           i_last = 1'b0;
   logic           bram_we;
   logic [WAW-1:0] bram_addr;
   logic [W-1:0]   bram_wdata;
   logic [W-1:0]   bram_wmask;
   logic           o_done;
   logic [WAW:0]   o_word_count;
`ifdef OFMAP_POPCOUNT_EN
   logic [BAW:0]   o_ones_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic           m_hv, m_clr, m_we, m_done;
   int             m_phase;
   logic [WAW-1:0] m_hwa, m_addr;
   logic [W-1:0]   m_hd, m_hm, m_wdata, m_wmask;
   logic [WAW:0]   m_wc;
   logic [BAW:0]   m_ones;

   ofmap_bit_packer #(.DATA_WIDTH(W), .BIT_ADDR_WIDTH(BAW)) dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_addr(i_addr), .i_valid(i_valid),
      .i_last(i_last), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .bram_wmask(bram_wmask), .o_done(o_done),
`ifdef OFMAP_POPCOUNT_EN
      .o_ones_count(o_ones_count),
`endif
      .o_word_count(o_word_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_hv = 0; m_clr = 0; m_we = 0; m_done = 0; m_phase = 0;
      m_hwa = '0; m_addr = '0; m_hd = '0; m_hm = '0; m_wdata = '0; m_wmask = '0;
      m_wc = '0; m_ones = '0;
   endtask

   task automatic model_emit(input logic [WAW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
      m_we = 1; m_addr = a; m_wdata = d; m_wmask = m;
      if (m_wc != '1) m_wc = m_wc + 1'b1;
   endtask

   // phase: 0 = accepting, 2 = flush pending, 1 = done pending
   task automatic model_edge(input logic v, input logic d, input logic [BAW-1:0] a, input logic l);
      int unsigned    wa, bp;
      logic [W-1:0]   b1;
      wa = a / W;
      bp = a % W;
      b1 = 32'h1 << bp;
      m_we = 0;
      m_done = 0;
      if (m_phase == 0) begin
         if (v) begin
            if (m_clr) begin m_wc = '0; m_ones = '0; m_clr = 0; end
            if (d && m_ones != '1) m_ones = m_ones + 1'b1;
            if (m_hv && wa != m_hwa) begin
               model_emit(m_hwa, m_hd, m_hm);
               m_hwa = WAW'(wa); m_hd = d ? b1 : '0; m_hm = b1;
            end else begin
               if (!m_hv) begin m_hwa = WAW'(wa); m_hd = '0; m_hm = '0; m_hv = 1; end
               m_hd = d ? (m_hd | b1) : (m_hd & ~b1);
               m_hm = m_hm | b1;
               if (bp == W-1) begin model_emit(m_hwa, m_hd, m_hm); m_hv = 0; end
            end
         end
         if (l) m_phase = 2;
      end else if (m_phase == 2) begin
         if (m_hv) begin model_emit(m_hwa, m_hd, m_hm); m_hv = 0; end
         m_phase = 1;
      end else begin
         m_done = 1; m_clr = 1; m_phase = 0;
      end
   endtask

   task automatic drive(input logic v, input logic d, input logic [BAW-1:0] a, input logic l);
      i_valid = v; i_data = d; i_addr = a; i_last = l;
      @(posedge clk);
      model_edge(v, d, a, l);
      #1;
      i_valid = 0; i_last = 0;
   endtask

   task automatic reset_dut();
      i_valid = 0; i_last = 0; i_data = 0; i_addr = '0;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 0;
      #2;
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h wmask=%h done=%b wc=%0d, want all 0",
                  bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count);
      end
      reset_dut();
   endtask

   task automatic test_full_word();
      reset_dut();
      for (int a = 0; a < W; a++) begin
         drive(1, a[0], BAW'(a), 0);
         if (a < W-1) begin
            vectors++;
            if (bram_we !== 1'b0) begin
               miscompares++;
               $display("FAIL full_word_early_we: addr %0d got we=%b want 0", a, bram_we);
            end
         end
      end
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count} !==
          {1'b1, 7'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 8'd1}) begin
         miscompares++;
         $display("FAIL full_word: got we=%b addr=%h wdata=%h wmask=%h wc=%0d want 1 0 aaaaaaaa ffffffff 1",
                  bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (bram_we !== 1'b0 || bram_wdata !== 32'hAAAAAAAA) begin
         miscompares++;
         $display("FAIL full_word_hold: got we=%b wdata=%h want 0 aaaaaaaa", bram_we, bram_wdata);
      end
   endtask

   task automatic test_flush();
      reset_dut();
      for (int a = 64; a < 70; a++) drive(1, 1, BAW'(a), 0);
      drive(0, 0, '0, 1);
      vectors++;
      if (bram_we !== 1'b0 || o_done !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_last_edge: got we=%b done=%b want 0 0", bram_we, o_done);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count} !==
          {1'b1, 7'd2, 32'h3F, 32'h3F, 1'b0, 8'd1}) begin
         miscompares++;
         $display("FAIL flush_write: got we=%b addr=%h wdata=%h wmask=%h done=%b wc=%0d want 1 2 3f 3f 0 1",
                  bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b1 || bram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_done: got done=%b we=%b want 1 0", o_done, bram_we);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b0 || o_word_count !== 8'd1) begin
         miscompares++;
         $display("FAIL flush_after_done: got done=%b wc=%0d want 0 1", o_done, o_word_count);
      end
   endtask

   task automatic test_addr_change();
      reset_dut();
      drive(1, 1, 12'd5, 0);
      drive(1, 1, 12'd40, 0);
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask} !== {1'b1, 7'd0, 32'h20, 32'h20}) begin
         miscompares++;
         $display("FAIL addr_change_write: got we=%b addr=%h wdata=%h wmask=%h want 1 0 20 20",
                  bram_we, bram_addr, bram_wdata, bram_wmask);
      end
      drive(0, 0, '0, 1);
      drive(0, 0, '0, 0);
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count} !==
          {1'b1, 7'd1, 32'h100, 32'h100, 8'd2}) begin
         miscompares++;
         $display("FAIL addr_change_flush: got we=%b addr=%h wdata=%h wmask=%h wc=%0d want 1 1 100 100 2",
                  bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b1) begin
         miscompares++;
         $display("FAIL addr_change_done: got done=%b want 1", o_done);
      end
   endtask

   task automatic test_empty_last();
      reset_dut();
      drive(0, 0, '0, 1);
      drive(0, 0, '0, 0);
      vectors++;
      if (bram_we !== 1'b0 || o_done !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_last_k1: got we=%b done=%b want 0 0", bram_we, o_done);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b1 || bram_we !== 1'b0 || o_word_count !== 8'd0) begin
         miscompares++;
         $display("FAIL empty_last_done: got done=%b we=%b wc=%0d want 1 0 0", o_done, bram_we, o_word_count);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_last_pulse_width: got done=%b want 0", o_done);
      end
   endtask

   task automatic test_top_bit_with_last();
      reset_dut();
      drive(1, 1, 12'd31, 1);
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count} !==
          {1'b1, 7'd0, 32'h80000000, 32'h80000000, 8'd1}) begin
         miscompares++;
         $display("FAIL top_bit_write: got we=%b addr=%h wdata=%h wmask=%h wc=%0d want 1 0 80000000 80000000 1",
                  bram_we, bram_addr, bram_wdata, bram_wmask, o_word_count);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (bram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL top_bit_no_flush: got we=%b want 0", bram_we);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b1 || o_word_count !== 8'd1) begin
         miscompares++;
         $display("FAIL top_bit_done: got done=%b wc=%0d want 1 1", o_done, o_word_count);
      end
      drive(1, 0, 12'd100, 0);
      vectors++;
      if (o_word_count !== 8'd0 || bram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL count_clear: got wc=%0d we=%b want 0 0", o_word_count, bram_we);
      end
   endtask

   task automatic test_reset_mid_layer();
      reset_dut();
      for (int a = 0; a < 10; a++) drive(1, 1, BAW'(a), 0);
      rst_n = 0;
      #1;
      vectors++;
      if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got we=%b wdata=%h wc=%0d want all 0", bram_we, bram_wdata, o_word_count);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
      drive(0, 0, '0, 1);
      drive(0, 0, '0, 0);
      vectors++;
      if (bram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_no_write: got we=%b want 0", bram_we);
      end
      drive(0, 0, '0, 0);
      vectors++;
      if (o_done !== 1'b1 || o_word_count !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_mid_done: got done=%b wc=%0d want 1 0", o_done, o_word_count);
      end
   endtask

   task automatic test_saturate();
      reset_dut();
      for (int i = 0; i < 300; i++) begin
         drive(1, 1'(i), BAW'((i % 2) * 32 + 3), 0);
         vectors++;
         if (o_word_count !== m_wc) begin
            miscompares++;
            $display("FAIL saturate_step: cycle %0d got wc=%0d want %0d", i, o_word_count, m_wc);
         end
      end
      vectors++;
      if (o_word_count !== 8'hFF) begin
         miscompares++;
         $display("FAIL saturate_final: got wc=%0d want 255", o_word_count);
      end
   endtask

   task automatic test_random();
      int unsigned seq = 0;
      logic [BAW-1:0] a;
      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            a = BAW'(seq);
            seq = (seq + 1) % (1 << BAW);
         end else begin
            a = BAW'($urandom_range(5, 0) * W + $urandom_range(W-1, 0));
         end
         drive($urandom_range(9, 0) < 7, 1'($urandom), a, $urandom_range(49, 0) == 0);
         vectors++;
         if ({bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count} !==
             {m_we, m_addr, m_wdata, m_wmask, m_done, m_wc}) begin
            miscompares++;
            $display("FAIL random_cycle %0d: got we=%b addr=%h wdata=%h wmask=%h done=%b wc=%0d want %b %h %h %h %b %0d",
                     i, bram_we, bram_addr, bram_wdata, bram_wmask, o_done, o_word_count,
                     m_we, m_addr, m_wdata, m_wmask, m_done, m_wc);
         end
`ifdef OFMAP_POPCOUNT_EN
         vectors++;
         if (o_ones_count !== m_ones) begin
            miscompares++;
            $display("FAIL random_ones %0d: got %0d want %0d", i, o_ones_count, m_ones);
         end
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_word();
      test_flush();
      test_addr_change();
      test_empty_last();
      test_top_bit_with_last();
      test_reset_mid_layer();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
